// File: rtl/deserializer.sv
// Serial-to-parallel receiver: gathers Depth slices of Width bits, lowest slice first,
// and presents the rebuilt word in a one-word holding register with a valid/ready
// handshake so the next word can assemble while the previous one waits.
module deserializer #(
  parameter int unsigned Depth = 1,
  parameter int unsigned Width = 1
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [Width-1:0]       serial_in_i,
  input  logic                   serial_valid_i,
  output logic                   serial_ready_o,
  input  logic                   abort_i,
  output logic [Depth*Width-1:0] parallel_out_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o
);

  localparam int unsigned WordW = Depth * Width;
  localparam int unsigned CntW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Depth - 1);

  logic [CntW-1:0]  count_q, count_d;
  logic [WordW-1:0] word_q, word_d;
  logic             out_valid_q, out_valid_d;

  logic             last_slot;
  logic             accept;
  logic             final_beat;
  logic [WordW-1:0] next_word;

  // Handshake decode; only the final beat can stall, and only behind an untaken word.
  always_comb begin
    last_slot      = (count_q == LastCnt);
    serial_ready_o = ~(last_slot & out_valid_q & ~out_ready_i);
    accept         = serial_valid_i & serial_ready_o & ~abort_i;
    final_beat     = accept & last_slot;
  end

  // Assembly path: the newest slice enters at the top and older slices move toward the LSB.
  if (Depth == 1) begin : g_single
    assign next_word = serial_in_i;
  end else begin : g_multi
    // Only the upper Depth-1 slices are kept; the lowest would be shifted out on the
    // final beat anyway.
    localparam int unsigned AsmW = WordW - Width;

    logic [AsmW-1:0] assembly_q, assembly_d;

    assign next_word = {serial_in_i, assembly_q};

    // Shift in the new slice on every accepted beat; stale bits after abort are overwritten.
    always_comb begin
      assembly_d = assembly_q;
      if (accept) begin
        assembly_d = next_word[WordW-1:Width];
      end
    end

    // Assembly register.
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        assembly_q <= '0;
      end else begin
        assembly_q <= assembly_d;
      end
    end
  end

  // Beat counter and holding-register next state.
  always_comb begin
    count_d     = count_q;
    word_d      = word_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (abort_i) begin
      count_d = '0;
    end else if (final_beat) begin
      count_d     = '0;
      word_d      = next_word;
      out_valid_d = 1'b1;
    end else if (accept) begin
      count_d = count_q + CntW'(1);
    end
  end

  // Counter, holding register and valid flag.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      count_q     <= '0;
      word_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign parallel_out_o = word_q;
  assign out_valid_o    = out_valid_q;
  assign busy_o         = (count_q != '0);

  // The counter must never run past the last slot.
  a_count_bound: assert property (@(posedge clock_i) disable iff (reset_i)
    count_q <= LastCnt);

  // An untaken word must neither vanish nor change under the consumer.
  a_hold_word: assert property (@(posedge clock_i) disable iff (reset_i)
    (out_valid_q && !out_ready_i) |=> (out_valid_q && $stable(word_q)));

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the deserializer: a Depth=4/Width=8 instance for the main cases and
// a Depth=1/Width=8 instance for the pass-through case, plus a randomised scoreboard run.
module tb_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic [7:0]  serial_in4;
  logic        serial_valid4, serial_ready4, abort4;
  logic [31:0] parallel_out4;
  logic        out_valid4, out_ready4, busy4;

  logic [7:0]  serial_in1;
  logic        serial_valid1, serial_ready1, abort1;
  logic [7:0]  parallel_out1;
  logic        out_valid1, out_ready1, busy1;

  int checks = 0;
  int errors = 0;

  deserializer #(.Depth(4), .Width(8)) u_dut4 (
    .clock_i        (clk),
    .reset_i        (reset),
    .serial_in_i    (serial_in4),
    .serial_valid_i (serial_valid4),
    .serial_ready_o (serial_ready4),
    .abort_i        (abort4),
    .parallel_out_o (parallel_out4),
    .out_valid_o    (out_valid4),
    .out_ready_i    (out_ready4),
    .busy_o         (busy4)
  );

  deserializer #(.Depth(1), .Width(8)) u_dut1 (
    .clock_i        (clk),
    .reset_i        (reset),
    .serial_in_i    (serial_in1),
    .serial_valid_i (serial_valid1),
    .serial_ready_o (serial_ready1),
    .abort_i        (abort1),
    .parallel_out_o (parallel_out1),
    .out_valid_o    (out_valid1),
    .out_ready_i    (out_ready1),
    .busy_o         (busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one slice to the Depth=4 instance and hold it until accepted (bounded).
  task automatic beat4(input logic [7:0] d);
    int n;
    n = 0;
    serial_valid4 = 1'b1;
    serial_in4    = d;
    @(negedge clk);
    while (!serial_ready4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!serial_ready4) check_eq("beat_timeout", {31'd0, serial_ready4}, 32'd1);
    @(posedge clk);
    #1;
    serial_valid4 = 1'b0;
  endtask

  logic [31:0] sh;
  logic [31:0] sb[$];
  logic [31:0] cur_word;
  logic [31:0] exp_word;
  int          sent_words, got_words, slice, cyc;
  logic        acc;

  initial begin
    reset = 1'b1;
    serial_in4 = '0; serial_valid4 = 1'b0; abort4 = 1'b0; out_ready4 = 1'b1;
    serial_in1 = '0; serial_valid1 = 1'b0; abort1 = 1'b0; out_ready1 = 1'b1;
    tick();
    tick();
    check_eq("rst_pout", parallel_out4, 32'h0);
    check_eq("rst_valid", {31'd0, out_valid4}, 32'd0);
    check_eq("rst_busy", {31'd0, busy4}, 32'd0);
    reset = 1'b0;
    tick();
    check_eq("idle_ready", {31'd0, serial_ready4}, 32'd1);

    // Case 1: basic word, consumer always ready.
    beat4(8'h11);
    beat4(8'h22);
    check_eq("c1_busy", {31'd0, busy4}, 32'd1);
    check_eq("c1_novalid", {31'd0, out_valid4}, 32'd0);
    beat4(8'h33);
    beat4(8'h44);
    check_eq("c1_valid", {31'd0, out_valid4}, 32'd1);
    check_eq("c1_word", parallel_out4, 32'h44332211);
    check_eq("c1_idle", {31'd0, busy4}, 32'd0);
    tick();
    check_eq("c1_taken", {31'd0, out_valid4}, 32'd0);

    // Case 2: held word stalls only the final beat of the next word.
    out_ready4 = 1'b0;
    beat4(8'h01); beat4(8'h02); beat4(8'h03); beat4(8'h04);
    check_eq("c2_a_valid", {31'd0, out_valid4}, 32'd1);
    check_eq("c2_a_word", parallel_out4, 32'h04030201);
    beat4(8'h05); beat4(8'h06); beat4(8'h07);
    check_eq("c2_a_held", parallel_out4, 32'h04030201);
    check_eq("c2_busy", {31'd0, busy4}, 32'd1);
    serial_valid4 = 1'b1;
    serial_in4    = 8'h08;
    @(negedge clk);
    check_eq("c2_stall", {31'd0, serial_ready4}, 32'd0);
    tick();
    check_eq("c2_still_a", parallel_out4, 32'h04030201);
    check_eq("c2_still_valid", {31'd0, out_valid4}, 32'd1);
    @(negedge clk);
    out_ready4 = 1'b1;
    #1;
    check_eq("c2_ready_comb", {31'd0, serial_ready4}, 32'd1);
    tick();
    serial_valid4 = 1'b0;
    check_eq("c2_b_valid", {31'd0, out_valid4}, 32'd1);
    check_eq("c2_b_word", parallel_out4, 32'h08070605);
    tick();
    check_eq("c2_b_taken", {31'd0, out_valid4}, 32'd0);

    // Case 3: abort drops the partial word and the beat in the same cycle.
    out_ready4 = 1'b0;
    beat4(8'h10); beat4(8'h20); beat4(8'h30); beat4(8'h40);
    beat4(8'hAA); beat4(8'hBB);
    serial_valid4 = 1'b1;
    serial_in4    = 8'hCC;
    abort4        = 1'b1;
    tick();
    abort4        = 1'b0;
    serial_valid4 = 1'b0;
    check_eq("c3_busy", {31'd0, busy4}, 32'd0);
    check_eq("c3_held_valid", {31'd0, out_valid4}, 32'd1);
    check_eq("c3_held_word", parallel_out4, 32'h40302010);
    beat4(8'h01); beat4(8'h02); beat4(8'h03);
    check_eq("c3_held_again", parallel_out4, 32'h40302010);
    out_ready4 = 1'b1;
    beat4(8'h04);
    check_eq("c3_word", parallel_out4, 32'h04030201);
    check_eq("c3_valid", {31'd0, out_valid4}, 32'd1);
    tick();

    // Case 4: reset in mid-word with a pending word.
    out_ready4 = 1'b0;
    beat4(8'h55); beat4(8'h66); beat4(8'h77); beat4(8'h88);
    beat4(8'h99); beat4(8'hAB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("c4_valid", {31'd0, out_valid4}, 32'd0);
    check_eq("c4_busy", {31'd0, busy4}, 32'd0);
    check_eq("c4_pout", parallel_out4, 32'h0);
    out_ready4 = 1'b1;
    beat4(8'h9A); beat4(8'hBC); beat4(8'hDE); beat4(8'hF0);
    check_eq("c4_word", parallel_out4, 32'hF0DEBC9A);
    tick();

    // Case 5: loopback from a shifter emitting its low slice first.
    sh = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      beat4(sh[7:0]);
      sh = sh >> 8;
    end
    check_eq("c5_loop", parallel_out4, 32'hDEADBEEF);
    tick();

    // Depth=1: each beat is its own word; stall only behind an untaken word.
    out_ready1    = 1'b0;
    serial_valid1 = 1'b1;
    serial_in1    = 8'h5A;
    tick();
    check_eq("d1_word", {24'd0, parallel_out1}, 32'h5A);
    check_eq("d1_valid", {31'd0, out_valid1}, 32'd1);
    check_eq("d1_busy", {31'd0, busy1}, 32'd0);
    serial_in1 = 8'hC3;
    @(negedge clk);
    check_eq("d1_stall", {31'd0, serial_ready1}, 32'd0);
    out_ready1 = 1'b1;
    tick();
    check_eq("d1_word2", {24'd0, parallel_out1}, 32'hC3);
    check_eq("d1_valid2", {31'd0, out_valid1}, 32'd1);
    serial_valid1 = 1'b0;
    tick();
    check_eq("d1_taken", {31'd0, out_valid1}, 32'd0);

    // Case 6: random valid/ready, scoreboard of 1000 words.
    sent_words = 0;
    got_words  = 0;
    slice      = 0;
    cyc        = 0;
    cur_word   = $urandom;
    while (got_words < 1000 && cyc < 60000) begin
      serial_valid4 = (sent_words < 1000) && ($urandom_range(3) != 0);
      serial_in4    = cur_word[slice*8 +: 8];
      out_ready4    = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = serial_valid4 && serial_ready4;
      if (out_valid4 && out_ready4) begin
        if (sb.size() == 0) begin
          check_eq("sb_extra", 32'd1, 32'd0);
        end else begin
          exp_word = sb.pop_front();
          check_eq("sb_word", parallel_out4, exp_word);
          got_words++;
        end
      end
      tick();
      cyc++;
      if (acc) begin
        slice++;
        if (slice == 4) begin
          slice = 0;
          sb.push_back(cur_word);
          sent_words++;
          cur_word = $urandom;
        end
      end
    end
    serial_valid4 = 1'b0;
    check_eq("sb_count", got_words, 32'd1000);
    check_eq("sb_left", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
